// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding, grant IDs
// and the default access latency.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_DATA  = 1'b0,
        GNT_INSTR = 1'b1
    } grant_t;

    localparam int DEFAULT_LATENCY = 5;

    function automatic int counter_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/latency_counter.sv
// Access timer: loads LATENCY, counts down by one per enabled cycle and
// saturates at zero.
module latency_counter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    localparam int W = counter_width(LATENCY)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (load) begin
            count <= W'(LATENCY);
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (data / instruction) arbiter in front of a single fixed-latency memory.
// Ties alternate between the sides; each transaction is IDLE -> ACCESS x LATENCY -> DONE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DW      = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    input  logic          i_req,
    input  logic [DW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CNT_W = counter_width(LATENCY);

    state_t             state;
    state_t             state_next;
    grant_t             grant;
    grant_t             grant_next;
    grant_t             last_grant;
    logic               we_q;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [CNT_W-1:0]   count;
    logic               any_req;
    logic               finish;

    latency_counter #(.LATENCY(LATENCY)) u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .count (count),
        .zero  (cnt_zero)
    );

    assign any_req = d_req || i_req;
    // The zero term only guards against a stuck ACCESS; normally count==1 ends it.
    assign finish  = (state == ACCESS) && ((count == CNT_W'(1)) || cnt_zero);

    assign mem_en  = (state == ACCESS);
    assign mem_we  = finish && we_q;
    assign d_ready = (state == DONE) && (grant == GNT_DATA);
    assign i_ready = (state == DONE) && (grant == GNT_INSTR);

    always_comb begin
        grant_next = GNT_DATA;
        if (d_req && i_req) begin
            if (last_grant == GNT_DATA) begin
                grant_next = GNT_INSTR;
            end
        end else if (i_req) begin
            grant_next = GNT_INSTR;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                    cnt_load   = 1'b1;
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            grant      <= GNT_DATA;
            last_grant <= GNT_INSTR;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            d_rdata    <= '0;
            i_rdata    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant      <= grant_next;
                last_grant <= grant_next;
                if (grant_next == GNT_DATA) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    we_q      <= d_we;
                end else begin
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                    we_q      <= 1'b0;
                end
            end
            // Writes leave the read-data registers untouched.
            if (finish && !we_q) begin
                if (grant == GNT_DATA) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at LATENCY=5, one at LATENCY=1,
// sharing clock and reset.
module tb_mem_port_arbiter;

    localparam int DW = 32;

    logic          CLK;
    logic          RESET;

    logic          d_req, d_we, i_req;
    logic [DW-1:0] d_addr, d_wdata, i_addr, mem_rdata;
    logic          d_ready, i_ready, mem_en, mem_we;
    logic [DW-1:0] d_rdata, i_rdata, mem_addr, mem_wdata;

    logic          l1_d_req, l1_d_we, l1_i_req;
    logic [DW-1:0] l1_d_addr, l1_d_wdata, l1_i_addr, l1_mem_rdata;
    logic          l1_d_ready, l1_i_ready, l1_mem_en, l1_mem_we;
    logic [DW-1:0] l1_d_rdata, l1_i_rdata, l1_mem_addr, l1_mem_wdata;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter #(.LATENCY(5), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.LATENCY(1), .DW(DW)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_ready(l1_d_ready), .d_rdata(l1_d_rdata),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ready(l1_i_ready), .i_rdata(l1_i_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Steps through one LATENCY=5 transaction from the grant edge to the ready cycle.
    task automatic observe_txn(input string tag, input bit exp_data, input bit exp_write,
                               input logic [DW-1:0] exp_addr, input logic [DW-1:0] exp_wdata);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check_output($sformatf("%s c%0d mem_en", tag, c), DW'(mem_en), DW'(c <= 5));
            check_output($sformatf("%s c%0d mem_we", tag, c), DW'(mem_we), DW'(exp_write && c == 5));
            check_output($sformatf("%s c%0d d_ready", tag, c), DW'(d_ready), DW'(exp_data && c == 6));
            check_output($sformatf("%s c%0d i_ready", tag, c), DW'(i_ready), DW'(!exp_data && c == 6));
            if (c <= 5) begin
                check_output($sformatf("%s c%0d mem_addr", tag, c), mem_addr, exp_addr);
            end
            if (exp_write && c == 5) begin
                check_output($sformatf("%s mem_wdata", tag), mem_wdata, exp_wdata);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, " mem_en"}, DW'(mem_en), '0);
        check_output({tag, " d_ready"}, DW'(d_ready), '0);
        check_output({tag, " i_ready"}, DW'(i_ready), '0);
    endtask

    initial begin
        RESET = 1'b0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; i_req = 0; i_addr = '0; mem_rdata = '0;
        l1_d_req = 0; l1_d_we = 0; l1_d_addr = '0; l1_d_wdata = '0;
        l1_i_req = 0; l1_i_addr = '0; l1_mem_rdata = '0;
        tick();
        tick();

        $display("[TB] reset state");
        check_output("rst d_ready", DW'(d_ready), '0);
        check_output("rst i_ready", DW'(i_ready), '0);
        check_output("rst mem_en", DW'(mem_en), '0);
        check_output("rst mem_we", DW'(mem_we), '0);
        check_output("rst mem_addr", mem_addr, '0);
        check_output("rst mem_wdata", mem_wdata, '0);
        check_output("rst d_rdata", d_rdata, '0);
        check_output("rst i_rdata", i_rdata, '0);

        $display("[TB] data read");
        RESET = 1'b1;
        d_req = 1; d_we = 0; d_addr = 32'h0000_0810; mem_rdata = 32'h1234_5678;
        observe_txn("rd", 1'b1, 1'b0, 32'h0000_0810, '0);
        check_output("rd d_rdata", d_rdata, 32'h1234_5678);
        d_req = 0;
        tick();
        check_quiet("rd idle");

        $display("[TB] data write");
        d_req = 1; d_we = 1; d_addr = 32'h0000_0820; d_wdata = 32'hCAFE_F00D; mem_rdata = 32'hDEAD_BEEF;
        observe_txn("wr", 1'b1, 1'b1, 32'h0000_0820, 32'hCAFE_F00D);
        check_output("wr d_rdata kept", d_rdata, 32'h1234_5678);
        d_req = 0; d_we = 0;
        tick();
        check_quiet("wr idle");

        $display("[TB] contention");
        RESET = 1'b0;
        d_req = 1; i_req = 1; d_addr = 32'h0000_0100; i_addr = 32'h0000_0200; mem_rdata = 32'h1111_2222;
        tick();
        RESET = 1'b1;
        observe_txn("ct1 data", 1'b1, 1'b0, 32'h0000_0100, '0);
        tick();
        check_quiet("ct gap1");
        observe_txn("ct2 instr", 1'b0, 1'b0, 32'h0000_0200, '0);
        check_output("ct i_rdata", i_rdata, 32'h1111_2222);
        tick();
        check_quiet("ct gap2");
        observe_txn("ct3 data", 1'b1, 1'b0, 32'h0000_0100, '0);
        d_req = 0; i_req = 0;
        tick();
        check_quiet("ct idle");

        $display("[TB] reset mid-access");
        d_req = 1; d_we = 1; d_addr = 32'h0000_0830; d_wdata = 32'h55AA_55AA;
        tick();
        tick();
        tick();
        check_output("ra c3 mem_en", DW'(mem_en), 32'd1);
        RESET = 1'b0;
        #1;
        check_output("ra mem_en", DW'(mem_en), '0);
        check_output("ra mem_we", DW'(mem_we), '0);
        check_output("ra mem_addr", mem_addr, '0);
        check_output("ra mem_wdata", mem_wdata, '0);
        check_output("ra d_rdata", d_rdata, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output($sformatf("ra hold%0d mem_we", k), DW'(mem_we), '0);
            check_output($sformatf("ra hold%0d d_ready", k), DW'(d_ready), '0);
        end
        RESET = 1'b1;
        observe_txn("ra fresh", 1'b1, 1'b1, 32'h0000_0830, 32'h55AA_55AA);
        check_output("ra d_rdata after wr", d_rdata, '0);
        d_req = 0; d_we = 0;
        tick();
        check_quiet("ra idle");

        $display("[TB] request drop");
        i_req = 1; i_addr = 32'h0000_0900; mem_rdata = 32'h0BAD_CAFE;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 2) i_req = 0;
            check_output($sformatf("dr c%0d mem_en", c), DW'(mem_en), DW'(c <= 5));
            check_output($sformatf("dr c%0d i_ready", c), DW'(i_ready), DW'(c == 6));
            check_output($sformatf("dr c%0d mem_we", c), DW'(mem_we), '0);
        end
        check_output("dr i_rdata", i_rdata, 32'h0BAD_CAFE);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_quiet($sformatf("dr after%0d", k));
        end

        $display("[TB] latency 1");
        l1_d_req = 1; l1_d_we = 0; l1_d_addr = 32'h0000_0040; l1_mem_rdata = 32'h7777_8888;
        tick();
        check_output("l1 c1 mem_en", DW'(l1_mem_en), 32'd1);
        check_output("l1 c1 d_ready", DW'(l1_d_ready), '0);
        check_output("l1 c1 mem_addr", l1_mem_addr, 32'h0000_0040);
        tick();
        check_output("l1 c2 mem_en", DW'(l1_mem_en), '0);
        check_output("l1 c2 d_ready", DW'(l1_d_ready), 32'd1);
        check_output("l1 c2 d_rdata", l1_d_rdata, 32'h7777_8888);
        tick();
        check_output("l1 c3 mem_en", DW'(l1_mem_en), '0);
        check_output("l1 c3 d_ready", DW'(l1_d_ready), '0);
        tick();
        check_output("l1 c4 mem_en", DW'(l1_mem_en), 32'd1);
        tick();
        check_output("l1 c5 d_ready", DW'(l1_d_ready), 32'd1);
        l1_d_we = 1; l1_d_wdata = 32'hA5A5_0001; l1_mem_rdata = 32'h9999_0000;
        tick();
        check_output("l1 c6 mem_en", DW'(l1_mem_en), '0);
        tick();
        check_output("l1 c7 mem_en", DW'(l1_mem_en), 32'd1);
        check_output("l1 c7 mem_we", DW'(l1_mem_we), 32'd1);
        check_output("l1 c7 mem_wdata", l1_mem_wdata, 32'hA5A5_0001);
        tick();
        check_output("l1 c8 mem_we", DW'(l1_mem_we), '0);
        check_output("l1 c8 d_ready", DW'(l1_d_ready), 32'd1);
        check_output("l1 c8 d_rdata kept", l1_d_rdata, 32'h7777_8888);
        l1_d_req = 0; l1_d_we = 0;
        tick();
        check_output("l1 idle mem_en", DW'(l1_mem_en), '0);
        check_output("l1 idle d_ready", DW'(l1_d_ready), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 5, memory access cycles per transaction (legal 1..15).
REQ-002 Parameter DW, default 32, data and address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: ports CLK and RESET.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 d_req  input  1  data-side request; held high until d_ready.
REQ-007 d_we  input  1  data-side write (1) or read (0).
REQ-008 d_addr  input  DW  data-side byte address.
REQ-009 d_wdata  input  DW  data-side write data.
REQ-010 d_ready  output  1  one-cycle completion pulse to the data side.
REQ-011 d_rdata  output  DW  data-side read data, valid while d_ready is high.
REQ-012 i_req  input  1  instruction-side request (read only).
REQ-013 i_addr  input  DW  instruction-side byte address.
REQ-014 i_ready  output  1  one-cycle completion pulse to the instruction side.
REQ-015 i_rdata  output  DW  instruction read data, valid while i_ready is high.
REQ-016 mem_en  output  1  memory access in progress.
REQ-017 mem_we  output  1  memory write strobe.
REQ-018 mem_addr  output  DW  latched address to memory.
REQ-019 mem_wdata  output  DW  latched write data to memory.
REQ-020 mem_rdata  input  DW  combinational memory read data for mem_addr.

Function
REQ-021 FSM SHALL have states IDLE, ACCESS, DONE.
REQ-022 IDLE: requests sampled only here; if any request is high, grant per REQ-025, latch addr/we/wdata/grant into registers, load counter with LATENCY, and go to ACCESS.
REQ-023 ACCESS: mem_en=1; counter decrements each cycle; on counter==1, capture mem_rdata into the grantee's rdata register, pulse mem_we for one cycle if the latched we=1, and go to DONE.
REQ-024 DONE: pulse the grantee's ready for exactly one cycle; unconditionally return to IDLE.
REQ-025 Arbitration: single request is granted directly; if both are high, grant the side not granted last (last_grant register, updated on each grant).
REQ-026 Latency: grant edge to ready-high = LATENCY+1 cycles; back-to-back transactions SHALL be spaced LATENCY+2 cycles apart (one IDLE cycle between them).
REQ-027 Request dropped during ACCESS: ignored; the access completes and ready still pulses (no abort).
REQ-028 Request still high in the IDLE cycle after ready: treated as a new request.
REQ-029 Instruction-side requests never assert mem_we.
REQ-030 rdata registers hold their value until the next capture; on write transactions the rdata register is not updated.
REQ-031 mem_addr/mem_wdata SHALL remain stable for the full ACCESS duration.
REQ-032 LATENCY=1: ACCESS lasts one cycle; capture and mem_we occur in that cycle.

Reset
REQ-033 RESET low SHALL immediately force state IDLE, counter 0, d_ready=i_ready=mem_en=mem_we=0, mem_addr=mem_wdata=0, d_rdata=i_rdata=0, last_grant=instruction (data wins the first tie).
REQ-034 Reset asserted mid-ACCESS SHALL abort the transaction with no mem_we pulse and no ready pulse; after release, pending requests are re-arbitrated from IDLE.

Structure
REQ-035 Shared package mem_arb_pkg SHALL hold the state encoding (IDLE/ACCESS/DONE), grant IDs (GNT_DATA, GNT_INSTR), and the default LATENCY constant.
REQ-036 One sub-module, latency_counter (load, decrement, zero flag; width from LATENCY), SHALL implement the access timer.

Verification
REQ-037 Data read: d_req=1, d_addr=0x810, mem_rdata=0x12345678, LATENCY=5 -> mem_en high for 5 cycles, d_ready pulses at cycle 6, d_rdata=0x12345678, mem_we never high.
REQ-038 Data write: d_we=1, d_addr=0x820, d_wdata=0xCAFEF00D -> exactly one mem_we cycle (the 5th ACCESS cycle) with mem_addr=0x820, mem_wdata=0xCAFEF00D; d_rdata unchanged.
REQ-039 Contention: d_req and i_req both held high from reset release -> grants alternate data, instr, data; ready pulses spaced 7 cycles apart.
REQ-040 Reset mid-access: RESET low at ACCESS cycle 3 of a write -> no mem_we, no d_ready; all outputs 0; after release with d_req high, a fresh 5-cycle access starts.
REQ-041 Request drop: i_req deasserted at ACCESS cycle 2 -> i_ready still pulses at cycle 6; FSM returns to IDLE with no further grant.
REQ-042 LATENCY=1: single data read -> mem_en one cycle, d_ready the next cycle; back-to-back requests spaced 3 cycles apart.
